// File: rtl/bmp_saver_if.sv
// bmp_saver_if: SD block-write and SDRAM read-port signals between bmp_saver (master) and its environment (slave)
interface bmp_saver_if;
  logic        SD_Init_Complite;
  logic [31:0] SD_Addr_Block;
  logic [31:0] SD_SerialCount;
  logic        SD_Write;
  logic        SD_Enable;
  logic        SD_Complite;
  logic        SD_Fail;
  logic        SD_InPut_Data_Valid;
  logic [31:0] SD_InPut_Data_Addr;
  logic [31:0] SD_InPut_Data;
  logic        m_valid_read;
  logic        m_ready_read;
  logic [23:0] m_addr_read;
  logic        m_out_valid;
  logic [15:0] m_out_data;
  modport master (
    input  SD_Init_Complite, SD_Complite, SD_Fail, SD_InPut_Data_Valid, SD_InPut_Data_Addr,
           m_ready_read, m_out_valid, m_out_data,
    output SD_Addr_Block, SD_SerialCount, SD_Write, SD_Enable, SD_InPut_Data, m_valid_read, m_addr_read
  );
  modport slave (
    output SD_Init_Complite, SD_Complite, SD_Fail, SD_InPut_Data_Valid, SD_InPut_Data_Addr,
           m_ready_read, m_out_valid, m_out_data,
    input  SD_Addr_Block, SD_SerialCount, SD_Write, SD_Enable, SD_InPut_Data, m_valid_read, m_addr_read
  );
endinterface

// File: rtl/bmp_saver.sv
// bmp_saver: streams the SDRAM frame buffer to SD as a bottom-up 24-bit BMP file; BMP_SAVE_REPLICATE_EN widens nibbles to {n,n}
module bmp_saver #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int RETRY_MAX  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        BMPSave_En,
  input  logic [31:0] Start_Block,
  output logic        BMPSave_Busy,
  output logic        BMPSave_Complite,
  output logic        BMPSave_Fail,
  bmp_saver_if.master bus
);
  localparam int ROW   = (IMG_WIDTH * 3 + 3) / 4 * 4;
  localparam int IMG   = ROW * IMG_HEIGHT;
  localparam int FSIZE = 54 + IMG;
  localparam logic [1:0] PAD_N = 2'(ROW - IMG_WIDTH * 3);
  localparam logic [431:0] HDR = {64'd0, 32'd2835, 32'd2835, 32'(IMG), 32'd0, 16'd24, 16'd1,
    32'(IMG_HEIGHT), 32'(IMG_WIDTH), 32'd40, 32'd54, 32'd0, 32'(FSIZE), 8'h4D, 8'h42};
  localparam logic [3:0] IDLE = 4'd0, HEADER = 4'd1, PIX_REQ = 4'd2, PIX_WAIT = 4'd3, PIX_B = 4'd4,
    PIX_G = 4'd5, PIX_R = 4'd6, PAD = 4'd7, LAST = 4'd8, FLUSH = 4'd9, COMPLETE = 4'd10, FAIL = 4'd11;

  function automatic logic [7:0] expand(input logic [3:0] n);
`ifdef BMP_SAVE_REPLICATE_EN
    return {n, n};
`else
    return {n, 4'h0};
`endif
  endfunction

  logic [3:0]      state, nxt, ret;
  logic [8:0]      ptr;
  logic [7:0]      retry;
  logic [10:0]     h, v;
  logic [1:0]      pad;
  logic [11:0]     pix;
  logic            sd_en, we, last_col, row_done, unused_ok;
  logic [7:0]      wb;
  logic [3:0][7:0] mem [128];

  assign last_col = h == 11'(IMG_WIDTH - 1);
  assign row_done = pad == PAD_N;
  assign BMPSave_Busy = !(state inside {IDLE, COMPLETE, FAIL});
  assign BMPSave_Complite = state == COMPLETE;
  assign BMPSave_Fail = state == FAIL;
  assign bus.SD_Enable = sd_en;
  assign bus.SD_Write = sd_en;
  assign bus.SD_SerialCount = '0;
  assign bus.m_valid_read = state == PIX_REQ;
  assign bus.m_addr_read = {2'b00, v, h};
  assign unused_ok = ^{bus.SD_InPut_Data_Addr[31:7], bus.m_out_data[15:12]};

  always_comb begin
    we = state inside {HEADER, PIX_B, PIX_G, PIX_R} || (state == PAD && !row_done) || (state == LAST && ptr != 9'd0);
    wb = state == HEADER ? HDR[{ptr[5:0], 3'b000} +: 8] :
         state == PIX_B  ? expand(pix[11:8]) :
         state == PIX_G  ? expand(pix[7:4]) :
         state == PIX_R  ? expand(pix[3:0]) : 8'h00;
    nxt = state;
    case (state)
      IDLE:     nxt = BMPSave_En && bus.SD_Init_Complite ? HEADER : IDLE;
      HEADER:   nxt = ptr == 9'd53 ? PIX_REQ : HEADER;
      PIX_REQ:  nxt = bus.m_ready_read ? PIX_WAIT : PIX_REQ;
      PIX_WAIT: nxt = bus.m_out_valid ? PIX_B : PIX_WAIT;
      PIX_B:    nxt = PIX_G;
      PIX_G:    nxt = PIX_R;
      PIX_R:    nxt = last_col ? PAD : PIX_REQ;
      PAD:      nxt = !row_done ? PAD : v != 11'd0 ? PIX_REQ : LAST;
      LAST:     nxt = ptr == 9'd0 ? COMPLETE : LAST;
      default:  nxt = state;
    endcase
  end

  always_ff @(posedge clk)
    if (we && !rst) mem[ptr[8:2]][ptr[1:0]] <= wb;

  // a byte landing at 511 diverts to FLUSH; ret remembers where the byte stream resumes
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ret <= IDLE;
      ptr <= '0;
      retry <= '0;
      h <= '0;
      v <= '0;
      pad <= '0;
      pix <= '0;
      sd_en <= 1'b0;
      bus.SD_Addr_Block <= '0;
      bus.SD_InPut_Data <= '0;
    end else begin
      if (bus.SD_InPut_Data_Valid) bus.SD_InPut_Data <= mem[bus.SD_InPut_Data_Addr[6:0]];
      if (state == FLUSH) begin
        if (sd_en && bus.SD_Complite) begin
          sd_en <= 1'b0;
          bus.SD_Addr_Block <= bus.SD_Addr_Block + 32'd1;
          retry <= '0;
          state <= ret;
        end else if (sd_en && bus.SD_Fail) begin
          sd_en <= 1'b0;
          retry <= retry + 8'd1;
          if (retry == 8'(RETRY_MAX)) state <= FAIL;
        end else sd_en <= 1'b1;
      end else begin
        state <= we && ptr == 9'd511 ? FLUSH : nxt;
        ret <= nxt;
        if (we) ptr <= ptr + 9'd1;
        if (state == IDLE && nxt == HEADER) begin
          bus.SD_Addr_Block <= Start_Block;
          v <= 11'(IMG_HEIGHT - 1);
          h <= '0;
          ptr <= '0;
        end
        if (state == PIX_WAIT && bus.m_out_valid) pix <= bus.m_out_data[11:0];
        if (state == PIX_R && !last_col) h <= h + 11'd1;
        if (state == PAD) begin
          pad <= row_done ? 2'd0 : pad + 2'd1;
          if (row_done) h <= '0;
          if (row_done && v != 11'd0) v <= v - 11'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bmp_saver.sv
// tb_bmp_saver: directed checks of bmp_saver on a 99x4 image (ROW=300, 3 pad bytes, FSIZE=1254, three blocks)
module tb_bmp_saver;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [31:0] start_blk = '0;
  logic        busy, done, fail;
  int          errs = 0, checks = 0;

  bmp_saver_if bus();
  bmp_saver #(.IMG_WIDTH(99), .IMG_HEIGHT(4), .RETRY_MAX(3)) dut (
    .clk(clk), .rst(rst), .BMPSave_En(en), .Start_Block(start_blk),
    .BMPSave_Busy(busy), .BMPSave_Complite(done), .BMPSave_Fail(fail), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] hdr [54] = '{
    8'h42, 8'h4D, 8'hE6, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h36, 8'h00, 8'h00, 8'h00, 8'h28, 8'h00, 8'h00, 8'h00,
    8'h63, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00,
    8'h01, 8'h00, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'hB0, 8'h04, 8'h00, 8'h00, 8'h13, 8'h0B, 8'h00, 8'h00, 8'h13, 8'h0B, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  logic [7:0]  file_b [1536];
  logic [31:0] blk [128];
  logic [31:0] att_q [$];
  logic [31:0] run_base = '0;
  logic [23:0] first_a, last_a, rd_a;
  int fail_left = 0, stall_n = 0, req_n = 0, wr_bad = 0;
  int sd_ph = 0, sd_w = 0, sd_cur = 0, rd_ph = 0;
  bit sd_pend = 1'b0;

  function automatic logic [11:0] pixf(input logic [10:0] v, input logic [10:0] h);
    return {h[3:0], h[7:4], v[1:0], 2'b10};
  endfunction

  function automatic logic [7:0] xb(input logic [3:0] n);
`ifdef BMP_SAVE_REPLICATE_EN
    return {n, n};
`else
    return {n, 4'h0};
`endif
  endfunction

  function automatic logic [7:0] exp_byte(input int i);
    int j, c;
    logic [11:0] p;
    if (i < 54) return hdr[i];
    j = i - 54;
    if (j >= 1200) return 8'h00;
    c = j % 300;
    if (c >= 297) return 8'h00;
    p = pixf(11'(3 - j / 300), 11'(c / 3));
    return xb(c % 3 == 0 ? p[11:8] : c % 3 == 1 ? p[7:4] : p[3:0]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_file(input string tag);
    for (int i = 0; i < 1536; i++) chk($sformatf("%s byte %0d", tag, i), 32'(file_b[i]), 32'(exp_byte(i)));
  endtask

  task automatic start_run(input logic [31:0] base, input int fails, input int stall);
    en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    att_q.delete();
    req_n = 0;
    fail_left = fails;
    stall_n = stall;
    run_base = base;
    foreach (file_b[i]) file_b[i] = 'x;
    start_blk = base;
    rst = 1'b0;
    en = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(done === 1'b1 || fail === 1'b1) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " finished in time"}, 32'(n < 20000), 32'd1);
    en = 1'b0;
  endtask

  // SD controller model: fetch 128 words per attempt, then pulse fail or complete
  always @(negedge clk) begin
    bus.SD_Complite = 1'b0;
    bus.SD_Fail = 1'b0;
    bus.SD_InPut_Data_Valid = 1'b0;
    if (rst) begin
      sd_ph = 0;
      sd_pend = 1'b0;
      bus.SD_InPut_Data_Addr = '0;
    end else begin
      if (bus.SD_Enable === 1'b1 && bus.SD_Write !== 1'b1) wr_bad++;
      if (sd_pend) blk[sd_cur] = bus.SD_InPut_Data;
      sd_pend = 1'b0;
      if (sd_ph == 0 && bus.SD_Enable === 1'b1) begin
        att_q.push_back(bus.SD_Addr_Block);
        sd_w = 0;
        sd_ph = 1;
      end
      if (sd_ph == 1) begin
        if (sd_w < 128) begin
          bus.SD_InPut_Data_Valid = 1'b1;
          bus.SD_InPut_Data_Addr = 32'(sd_w);
          sd_cur = sd_w;
          sd_pend = 1'b1;
          sd_w++;
        end else begin
          if (fail_left > 0) begin
            bus.SD_Fail = 1'b1;
            fail_left--;
          end else begin
            logic [31:0] off;
            bus.SD_Complite = 1'b1;
            off = bus.SD_Addr_Block - run_base;
            if (off < 32'd3)
              for (int w = 0; w < 128; w++)
                for (int k = 0; k < 4; k++) file_b[int'(off) * 512 + w * 4 + k] = blk[w][8 * k +: 8];
          end
          sd_ph = 2;
        end
      end else if (sd_ph == 2 && bus.SD_Enable !== 1'b1) sd_ph = 0;
    end
  end

  // SDRAM model: optional stall, one-cycle ready, data on the following cycle
  always @(negedge clk) begin
    bus.m_ready_read = 1'b0;
    bus.m_out_valid = 1'b0;
    if (rst) begin
      rd_ph = 0;
      bus.m_out_data = '0;
    end else if (rd_ph == 1) begin
      bus.m_out_valid = 1'b1;
      bus.m_out_data = {4'hF, pixf(rd_a[21:11], rd_a[10:0])};
      rd_ph = 0;
    end else if (bus.m_valid_read === 1'b1) begin
      if (stall_n > 0) stall_n--;
      else begin
        bus.m_ready_read = 1'b1;
        rd_a = bus.m_addr_read;
        if (req_n == 0) first_a = rd_a;
        last_a = rd_a;
        req_n++;
        rd_ph = 1;
      end
    end
  end

  initial begin
    int n;
    logic [23:0] a0;
    bus.SD_Init_Complite = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst complete", 32'(done), 32'd0);
    chk("rst fail", 32'(fail), 32'd0);
    chk("rst sd_enable", 32'(bus.SD_Enable), 32'd0);
    chk("rst sd_write", 32'(bus.SD_Write), 32'd0);
    chk("rst sd_addr", bus.SD_Addr_Block, 32'd0);
    chk("rst serialcount", bus.SD_SerialCount, 32'd0);
    chk("rst sd_data", bus.SD_InPut_Data, 32'd0);
    chk("rst m_valid", 32'(bus.m_valid_read), 32'd0);
    chk("rst m_addr", 32'(bus.m_addr_read), 32'd0);
    rst = 1'b0;
    en = 1'b1;
    repeat (4) @(negedge clk);
    chk("no start without init busy", 32'(busy), 32'd0);
    chk("no start without init addr", bus.SD_Addr_Block, 32'd0);
    bus.SD_Init_Complite = 1'b1;

    start_run(32'd100, 0, 22);
    n = 0;
    while (bus.m_valid_read !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("first request seen", 32'(n < 200), 32'd1);
    a0 = bus.m_addr_read;
    chk("first request V=3 H=0", 32'(a0), 32'h001800);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("stall m_valid_read", 32'(bus.m_valid_read), 32'd1);
      chk("stall m_addr_read", 32'(bus.m_addr_read), 32'(a0));
    end
    wait_done("runA");
    chk("runA complete", 32'(done), 32'd1);
    chk("runA fail", 32'(fail), 32'd0);
    chk("runA busy", 32'(busy), 32'd0);
    chk("runA attempts", 32'(att_q.size()), 32'd3);
    chk("runA blk0 addr", att_q[0], 32'd100);
    chk("runA blk1 addr", att_q[1], 32'd101);
    chk("runA blk2 addr", att_q[2], 32'd102);
    chk("runA final sd_addr", bus.SD_Addr_Block, 32'd103);
    chk("runA requests", 32'(req_n), 32'd396);
    chk("runA first addr", 32'(first_a), 32'h001800);
    chk("runA last addr V=0 H=98", 32'(last_a), 32'h000062);
    chk("runA word0", {file_b[3], file_b[2], file_b[1], file_b[0]}, 32'h04E64D42);
    chk("runA IMG field", {file_b[37], file_b[36], file_b[35], file_b[34]}, 32'd1200);
    chk("runA last pad byte", 32'(file_b[1253]), 32'd0);
    chk("runA first fill byte", 32'(file_b[1254]), 32'd0);
    check_file("runA");

    start_run(32'd7, 2, 0);
    wait_done("runB");
    chk("runB complete", 32'(done), 32'd1);
    chk("runB attempts", 32'(att_q.size()), 32'd5);
    chk("runB try0 addr", att_q[0], 32'd7);
    chk("runB try1 addr", att_q[1], 32'd7);
    chk("runB try2 addr", att_q[2], 32'd7);
    chk("runB blk1 addr", att_q[3], 32'd8);
    chk("runB blk2 addr", att_q[4], 32'd9);
    check_file("runB");

    start_run(32'd7, 4, 0);
    wait_done("runC");
    chk("runC fail", 32'(fail), 32'd1);
    chk("runC complete", 32'(done), 32'd0);
    chk("runC busy", 32'(busy), 32'd0);
    chk("runC sd_enable", 32'(bus.SD_Enable), 32'd0);
    chk("runC sd_write", 32'(bus.SD_Write), 32'd0);
    chk("runC attempts", 32'(att_q.size()), 32'd4);
    chk("runC last try addr", att_q[3], 32'd7);
    repeat (5) @(negedge clk);
    chk("runC fail sticky", 32'(fail), 32'd1);

    start_run(32'd200, 0, 0);
    n = 0;
    while (att_q.size() < 2 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("runD second block reached", 32'(n < 20000), 32'd1);
    repeat (20) @(negedge clk);
    chk("runD mid-block sd_enable", 32'(bus.SD_Enable), 32'd1);
    en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("runD rst busy", 32'(busy), 32'd0);
    chk("runD rst complete", 32'(done), 32'd0);
    chk("runD rst fail", 32'(fail), 32'd0);
    chk("runD rst sd_enable", 32'(bus.SD_Enable), 32'd0);
    chk("runD rst sd_write", 32'(bus.SD_Write), 32'd0);
    chk("runD rst sd_addr", bus.SD_Addr_Block, 32'd0);
    chk("runD rst sd_data", bus.SD_InPut_Data, 32'd0);
    chk("runD rst m_valid", 32'(bus.m_valid_read), 32'd0);
    chk("runD rst m_addr", 32'(bus.m_addr_read), 32'd0);
    @(negedge clk);
    att_q.delete();
    req_n = 0;
    foreach (file_b[i]) file_b[i] = 'x;
    rst = 1'b0;
    @(negedge clk);
    chk("runD idle after rst", 32'(busy), 32'd0);
    en = 1'b1;
    wait_done("runD");
    chk("runD complete", 32'(done), 32'd1);
    chk("runD attempts", 32'(att_q.size()), 32'd3);
    chk("runD restart addr", att_q[0], 32'd200);
    chk("runD last addr", att_q[2], 32'd202);
    check_file("runD");

    chk("sd_write tracks sd_enable", 32'(wr_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/bmp_saver.md
Name: bmp_saver

Overview:
- Writes the SDRAM frame buffer to the SD card as an uncompressed 24-bit BMP file (screenshot path).
- Source is the SDRAM read port: 11-bit H / 11-bit V addressing, RGB444 pixels in 16-bit words.
- Sink is the SD controller block-write data interface.
- Streams the 54-byte header, then bottom-up padded pixel rows, through a local 512-byte block buffer, writing one SD block at a time.

Parameters:
- IMG_WIDTH, 640, image width in pixels (1..2047).
- IMG_HEIGHT, 480, image height in pixels (1..2047).
- RETRY_MAX, 3, SD write failures tolerated per block before aborting.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- BMPSave_En  in  1  start request (level), sampled in IDLE.
- Start_Block  in  32  SD block address of file byte 0, latched at start.
- BMPSave_Busy  out  1  high in any state other than IDLE/COMPLETE/FAIL.
- BMPSave_Complite  out  1  sticky done flag.
- BMPSave_Fail  out  1  sticky fail flag.
- SD_Init_Complite  in  1  SD card ready.
- SD_Addr_Block  out  32  block being written.
- SD_SerialCount  out  32  tied 0 (single-block transfers).
- SD_Write  out  1  write-mode select, high with SD_Enable.
- SD_Enable  out  1  transfer request.
- SD_Complite  in  1  transfer done.
- SD_Fail  in  1  transfer failed.
- SD_InPut_Data_Valid  in  1  controller requests a word.
- SD_InPut_Data_Addr  in  32  word index 0..127 within the block.
- SD_InPut_Data  out  32  requested word.
- m_valid_read  out  1  SDRAM read request.
- m_ready_read  in  1  request accepted.
- m_addr_read  out  24  {2'b0, V[10:0], H[10:0]}.
- m_out_valid  in  1  read data strobe.
- m_out_data  in  16  pixel: [11:8] B, [7:4] G, [3:0] R.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; byte pointer, retry count, H and V all 0.
- Derived constants:
  - ROW = IMG_WIDTH*3 rounded up to a multiple of 4.
  - IMG = ROW*IMG_HEIGHT.
  - FSIZE = 54 + IMG.
- Header bytes, little-endian fields:
  - 'B','M', FSIZE, 0 (4 bytes), 54, 40, IMG_WIDTH, IMG_HEIGHT.
  - planes 1 (2 bytes), bpp 24 (2 bytes), compression 0, IMG, 2835, 2835, 0, 0.
- Buffer: 512 bytes, one byte written per cycle at ptr[8:0].
  - Byte k of word w sits in SD_InPut_Data[8k+7:8k].
  - SD_InPut_Data is registered: valid on the cycle after SD_InPut_Data_Valid.
- IDLE -> HEADER when BMPSave_En & SD_Init_Complite. Latch Start_Block into SD_Addr_Block; V = IMG_HEIGHT-1, H = 0.
- HEADER: emits 54 bytes, one per cycle, then goes to PIX_REQ.
- PIX_REQ: assert m_valid_read; on m_ready_read&m_valid_read, drop it and go to PIX_WAIT. Exactly one request is outstanding at a time.
- PIX_WAIT: on m_out_valid, capture the pixel, then emit three bytes in successive cycles:
  - PIX_B from [11:8]
  - PIX_G from [7:4]
  - PIX_R from [3:0]
- Nibble expansion is per the optional feature.
- After PIX_R:
  - If H != IMG_WIDTH-1: H++ and go to PIX_REQ.
  - Otherwise go to PAD, which emits (ROW - IMG_WIDTH*3) zero bytes (0..3), then H = 0.
    - If V != 0: V-- and go to PIX_REQ.
    - Otherwise go to LAST.
- Block flush:
  - Whenever a byte is written at ptr=511, the FSM saves the return state, goes to FLUSH, and ptr wraps to 0.
  - In LAST, if ptr != 0, zero-fill to 511 then flush; after that, COMPLETE.
- FLUSH:
  - Hold SD_Enable = SD_Write = 1 and serve word requests.
  - SD_Complite: drop SD_Enable, SD_Addr_Block++, clear retry count, go to the return state.
  - SD_Fail: drop SD_Enable for one cycle, retry count++, re-enable the same block.
  - Once retry count reaches RETRY_MAX and SD_Fail arrives again: go to FAIL.
  - SD_Complite and SD_Fail in the same cycle: SD_Complite wins.
- COMPLETE asserts BMPSave_Complite; FAIL asserts BMPSave_Fail. Both hold until rst.
- Reset mid-operation: immediate return to reset values. No partial-block write is issued.
- Total blocks written = ceil(FSIZE/512).

Optional Feature:
- Macro: BMP_SAVE_REPLICATE_EN.
- Defined: each 4-bit channel n becomes byte {n,n}, so 0xF maps to 0xFF.
- Undefined: byte = {n,4'b0}, so 0xF maps to 0xF0. Header and timing are unchanged.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, Start_Block=100, pixel = 0x0ABC for every address:
  - Exactly one block is written, to address 100.
  - Word 0 = 0x004E4D42 (B,M,FSIZE low bytes 78,0); word 1 = 0x00000000.
  - Bytes 54..77 repeat AA,BB,CC with replication enabled; bytes 78..511 are 0.
- IMG_WIDTH=3, IMG_HEIGHT=1: ROW = 12.
  - Bytes 54..62 are pixel data, bytes 63..65 are 0, FSIZE = 66.
  - Header bytes 34..37 (IMG) = 12.
- IMG_WIDTH=100, IMG_HEIGHT=4: FSIZE = 1254.
  - Three blocks written, to Start_Block+0..2.
  - The third block carries 230 data bytes, then zeros.
  - SDRAM addresses are requested with V=3 first and V=0 last.
- SD_Fail on the first 2 attempts of block 0, with RETRY_MAX=3:
  - Block 0 is re-sent with the same address, then the save completes.
  - Four consecutive fails (RETRY_MAX+1) -> BMPSave_Fail=1 and SD_Enable=0.
- m_ready_read held low for 20 cycles:
  - m_valid_read stays high with m_addr_read stable, and no bytes are emitted.
- rst asserted during the second block:
  - The next cycle has all outputs 0 and state IDLE.
  - Asserting BMPSave_En restarts from Start_Block.
